// File: rtl/bcd_alu_if.sv
// bcd_alu_if: start/done handshake, operands and status results between the sequencer and its controller.
interface bcd_alu_if;
  logic       start, flush, c_in, sub, dec;
  logic [7:0] op_a, op_b;
  logic       busy, done, c_out, hc_out, z_out, n_out, v_out;
  logic [7:0] result;
  modport master(output start, flush, op_a, op_b, c_in, sub, dec,
                 input busy, done, result, c_out, hc_out, z_out, n_out, v_out);
  modport slave(input start, flush, op_a, op_b, c_in, sub, dec,
                output busy, done, result, c_out, hc_out, z_out, n_out, v_out);
endinterface

// File: rtl/bcd_alu_seq.sv
// bcd_alu_seq: 6502 ADC/SBC sequencer, one nibble per cycle through a shared binary/BCD add-correct stage.
module bcd_alu_seq #(
  parameter bit CORR_INVALID = 1'b1
) (
  input logic clk,
  input logic rst_n,
  bcd_alu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  state_t     state, state_nx;
  logic [7:0] a_q, b_q, eff_b, bsum, res;
  logic       cin_q, sub_q, dec_q, lc_q;
  logic [3:0] lo_q, nib_a, nib_b, nib_e, dig;
  logic [4:0] s;
  logic       nib_c, ok, need, dc, v;
  always_comb begin
    state_nx = bus.flush ? IDLE :
               state == IDLE ? (bus.start ? LO : IDLE) :
               state == LO   ? HI :
               state == HI   ? DONE : IDLE;
  end
  // Shared nibble stage: the low digit in LO, the high digit in HI.
  always_comb begin
    nib_a = state == HI ? a_q[7:4] : a_q[3:0];
    nib_b = state == HI ? b_q[7:4] : b_q[3:0];
    nib_c = state == HI ? lc_q : cin_q;
    nib_e = sub_q ? ~nib_b : nib_b;
    s     = {1'b0, nib_a} + {1'b0, nib_e} + {4'b0, nib_c};
    ok    = CORR_INVALID || (nib_a <= 4'd9 && nib_b <= 4'd9);
    need  = dec_q && ok && (sub_q ? !s[4] : s > 5'd9);
    dig   = need ? s[3:0] + (sub_q ? 4'hA : 4'h6) : s[3:0];
    dc    = need ? !sub_q : s[4];
    res   = {dig, lo_q};
    eff_b = sub_q ? ~b_q : b_q;
    bsum  = a_q + eff_b + {7'b0, cin_q};
    v     = (a_q[7] == eff_b[7]) && (bsum[7] != a_q[7]);
  end
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      sub_q      <= 1'b0;
      dec_q      <= 1'b0;
      lc_q       <= 1'b0;
      lo_q       <= '0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.c_out  <= 1'b0;
      bus.hc_out <= 1'b0;
      bus.z_out  <= 1'b0;
      bus.n_out  <= 1'b0;
      bus.v_out  <= 1'b0;
    end else begin
      state    <= state_nx;
      bus.done <= state == DONE && !bus.flush;
      if (state == IDLE && bus.start && !bus.flush) begin
        a_q   <= bus.op_a;
        b_q   <= bus.op_b;
        cin_q <= bus.c_in;
        sub_q <= bus.sub;
        dec_q <= bus.dec;
      end
      if (state == LO && !bus.flush) begin
        lo_q       <= dig;
        lc_q       <= dc;
        bus.hc_out <= dc;
      end
      if (state == HI && !bus.flush) begin
        bus.result <= res;
        bus.c_out  <= dc;
        bus.z_out  <= res == 8'h00;
        bus.n_out  <= res[7];
        bus.v_out  <= v;
      end
    end
  end
endmodule

// File: tb/tb_bcd_alu_seq.sv
// tb_bcd_alu_seq: directed vectors feed a scoreboard queue; a negedge monitor checks every done pulse.
module tb_bcd_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  bcd_alu_if bus();
  bcd_alu_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [7:0] a, b;
    logic       c, s, d;
    logic [7:0] r;
    logic       co, hc, v;
  } vec_t;
  typedef struct {
    vec_t v;
    int   t;
  } exp_t;
  exp_t q[$];
  vec_t vecs[10];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: done=1 with no expected result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("latency", cyc, e.t);
        chk("result", bus.result, e.v.r);
        chk("c_out", bus.c_out, e.v.co);
        chk("hc_out", bus.hc_out, e.v.hc);
        chk("z_out", bus.z_out, e.v.r == 8'h00);
        chk("n_out", bus.n_out, e.v.r[7]);
        chk("v_out", bus.v_out, e.v.v);
        chk("busy_in_done", bus.busy, 0);
      end
    end
  end
  task automatic drive(input vec_t v);
    bus.op_a = v.a;
    bus.op_b = v.b;
    bus.c_in = v.c;
    bus.sub  = v.s;
    bus.dec  = v.d;
  endtask
  task automatic issue(input vec_t v, input bit expect_done);
    @(negedge clk);
    drive(v);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (expect_done) q.push_back('{v: v, t: cyc + 3});
    bus.start = 1'b0;
    bus.op_a  = 8'hFF;
    bus.op_b  = 8'hFF;
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_result"}, bus.result, 0);
    chk({tag, "_c"}, bus.c_out, 0);
    chk({tag, "_hc"}, bus.hc_out, 0);
    chk({tag, "_z"}, bus.z_out, 0);
    chk({tag, "_n"}, bus.n_out, 0);
    chk({tag, "_v"}, bus.v_out, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    //          a      b      c     s     d     r      co    hc    v
    vecs[0] = '{8'h45, 8'h38, 1'b0, 1'b0, 1'b1, 8'h83, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h99, 8'h01, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h58, 8'h46, 1'b1, 1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{8'h50, 8'h01, 1'b1, 1'b1, 1'b1, 8'h49, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 8'h01, 1'b1, 1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{8'h80, 8'h01, 1'b1, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{8'h0A, 8'h00, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 8'h46, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{8'h11, 8'h11, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0};
    bus.start = 1'b0;
    bus.flush = 1'b0;
    drive(vecs[0]);
    #3;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i], 1'b1);
      repeat (4) @(posedge clk);
    end
    // start held high: a new op is accepted every 4 cycles, operand changes mid-op ignored
    @(negedge clk);
    drive(vecs[5]);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    q.push_back('{v: vecs[5], t: cyc + 3});
    drive(vecs[1]);
    repeat (4) @(posedge clk);
    #1;
    q.push_back('{v: vecs[1], t: cyc + 3});
    drive(vecs[0]);
    repeat (4) @(posedge clk);
    #1;
    q.push_back('{v: vecs[0], t: cyc + 3});
    bus.start = 1'b0;
    drive(vecs[4]);
    repeat (5) @(posedge clk);
    // flush during HI: no done, prior result kept
    issue(vecs[9], 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    chk("flush_busy", bus.busy, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("flush_result_kept", bus.result, 8'h83);
    chk("flush_n_kept", bus.n_out, 1);
    // async reset mid-HI
    issue(vecs[9], 1'b0);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    issue(vecs[8], 1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
